// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control supervisor: one-hot state
// encoding, default geometry and a small state-class helper.
package flow_ctrl_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 4;

    // One-hot encoding is visible on the 'state' port, so the values are fixed.
    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } fc_state_e;

    // True in the states where occupancy is supervised with hysteresis.
    function automatic logic is_supervising(input fc_state_e s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

    // True in the states where FIFO error pulses are recorded.
    function automatic logic records_errors(input fc_state_e s);
        return (s == ST_IDLE) || (s == ST_ACTIVE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/flow_ctrl_fsm_pause_hyst.sv
// Per-channel hysteretic back-pressure bit. Force-one dominates, then the
// threshold comparison when enabled; with neither, the bit is driven low.
module pause_hyst
    import flow_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] alto,
    input  logic [CNT_W-1:0] bajo,
    input  logic             enable,
    input  logic             force_one,
    output logic             pause
);

    logic pause_r;
    logic pause_next_s;

    // Next pause value: set wins over clear when both thresholds are met.
    always_comb begin
        pause_next_s = 1'b0;
        if (force_one) begin
            pause_next_s = 1'b1;
        end else if (enable) begin
            if (count >= alto) begin
                pause_next_s = 1'b1;
            end else if (count <= bajo) begin
                pause_next_s = 1'b0;
            end else begin
                pause_next_s = pause_r;
            end
        end else begin
            pause_next_s = 1'b0;
        end
    end

    // Pause register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause_r <= 1'b0;
        end else begin
            pause_r <= pause_next_s;
        end
    end

    assign pause = pause_r;

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Transaction-layer flow-control supervisor: sequencing FSM, threshold
// latches, sticky per-channel error record and per-channel pause cells.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [CNT_W-1:0]        umbral_alto_in,
    input  logic [CNT_W-1:0]        umbral_bajo_in,
    input  logic [NUM_CH*CNT_W-1:0] fifo_count,
    input  logic [NUM_CH-1:0]       fifo_err,
    output logic [CNT_W-1:0]        umbral_alto,
    output logic [CNT_W-1:0]        umbral_bajo,
    output logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH-1:0]       error_out,
    output logic                    idle,
    output logic [4:0]              state
);

    fc_state_e         state_r;
    fc_state_e         state_next_s;
    logic              idle_r;
    logic [CNT_W-1:0]  alto_r;
    logic [CNT_W-1:0]  bajo_r;
    logic [CNT_W-1:0]  alto_next_s;
    logic [CNT_W-1:0]  bajo_next_s;
    logic [NUM_CH-1:0] error_r;
    logic [NUM_CH-1:0] error_next_s;
    logic              any_count_s;
    logic              any_err_s;
    logic              pause_en_s;
    logic              pause_force_s;

    // Reduce per-channel occupancy and error pulses to single flags.
    always_comb begin
        any_count_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fifo_count[i*CNT_W +: CNT_W] != {CNT_W{1'b0}}) begin
                any_count_s = 1'b1;
            end else begin
                any_count_s = any_count_s;
            end
        end
        any_err_s = |fifo_err;
    end

    // Next-state logic; priority is init, then any error, then normal flow.
    always_comb begin
        state_next_s = ST_RESET;
        case (state_r)
            ST_RESET: begin
                state_next_s = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (init) begin
                    state_next_s = ST_INIT;
                end else if (any_err_s) begin
                    state_next_s = ST_ERROR;
                end else if (any_count_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (init) begin
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_ERROR;
                end
            end
            default: begin
                state_next_s = ST_RESET;
            end
        endcase
    end

    // Threshold capture while in INIT; frozen in every other state.
    always_comb begin
        alto_next_s = alto_r;
        bajo_next_s = bajo_r;
        if (state_r == ST_INIT) begin
            alto_next_s = umbral_alto_in;
            bajo_next_s = umbral_bajo_in;
        end else begin
            alto_next_s = alto_r;
            bajo_next_s = bajo_r;
        end
    end

    // Sticky error record: cleared on entry to INIT (which also swallows a
    // simultaneous pulse), accumulated in IDLE/ACTIVE/ERROR.
    always_comb begin
        error_next_s = error_r;
        if ((state_next_s == ST_INIT) && (state_r != ST_INIT)) begin
            error_next_s = {NUM_CH{1'b0}};
        end else if (records_errors(state_r)) begin
            error_next_s = error_r | fifo_err;
        end else begin
            error_next_s = error_r;
        end
    end

    // State, idle flag, thresholds and error record registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_RESET;
            idle_r  <= 1'b0;
            alto_r  <= {CNT_W{1'b0}};
            bajo_r  <= {CNT_W{1'b0}};
            error_r <= {NUM_CH{1'b0}};
        end else begin
            state_r <= state_next_s;
            idle_r  <= (state_next_s == ST_IDLE);
            alto_r  <= alto_next_s;
            bajo_r  <= bajo_next_s;
            error_r <= error_next_s;
        end
    end

    // Pause qualification: hysteresis uses the present state, while all-ones
    // must appear on the same edge that the FSM enters ERROR.
    always_comb begin
        pause_en_s    = is_supervising(state_r);
        pause_force_s = (state_r == ST_ERROR) || (state_next_s == ST_ERROR);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pause
        pause_hyst #(
            .CNT_W (CNT_W)
        ) u_pause (
            .clk       (clk),
            .reset_L   (reset_L),
            .count     (fifo_count[g*CNT_W +: CNT_W]),
            .alto      (alto_r),
            .bajo      (bajo_r),
            .enable    (pause_en_s),
            .force_one (pause_force_s),
            .pause     (pause[g])
        );
    end

    assign state       = state_r;
    assign idle        = idle_r;
    assign umbral_alto = alto_r;
    assign umbral_bajo = bajo_r;
    assign error_out   = error_r;

endmodule
